// File: rtl/uart_tx_mode1.sv
// uart_tx_mode1: 8051 serial mode 1 transmitter (start bit, 8 data bits
// LSB first, stop bit) paced by the Timer 1 baud strobe. A one-byte holding
// register (SBUF write side) lets back-to-back frames run with no idle gap.
// The design also provides an 8051-style sticky TI flag.
//
// Ports:
//   clk        main clock
//   rst        synchronous active-high reset
//   tick_baud  one-cycle baud strobe; one bit time = strobe interval
//   wr_en      SBUF write strobe, honoured only while wr_ready=1
//   wr_data    byte to send
//   wr_ready   holding register empty (combinational)
//   tx         serial line, idle high, registered
//   tx_busy    frame in progress or byte waiting in the holding register
//   tx_done    one-cycle pulse when a stop bit completes
//   ti         sticky transmit-interrupt flag
//   ti_clr     software clear of ti (a simultaneous set wins)
module uart_tx_mode1 #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_baud,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 ti,
  input  logic                 ti_clr
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;

  // Status outputs derived directly from registered state.
  assign wr_ready = !hold_full;
  assign tx_busy  = (state != IDLE) || hold_full;

  // Holding register, frame FSM, line driver and TI flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
      ti        <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      // Clear first so that a stop completion below overrides it.
      if (ti_clr) begin
        ti <= 1'b0;
      end

      // A launch needs hold_full=1 and a write needs hold_full=0, so the
      // two never update hold_full in the same cycle.
      if (wr_en && !hold_full) begin
        hold      <= wr_data;
        hold_full <= 1'b1;
      end

      if (tick_baud) begin
        case (state)
          IDLE: begin
            if (hold_full) begin
              tx        <= 1'b0;
              shift     <= hold;
              hold_full <= 1'b0;
              bit_cnt   <= '0;
              state     <= START;
            end
          end

          START: begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= CNT_W'(1);
            state   <= DATA;
          end

          DATA: begin
            if (bit_cnt < CNT_W'(DATA_BITS)) begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else begin
              tx    <= 1'b1;
              state <= STOP;
            end
          end

          STOP: begin
            tx_done <= 1'b1;
            ti      <= 1'b1;
            // Chain straight into the next frame when a byte is waiting.
            if (hold_full) begin
              tx        <= 1'b0;
              shift     <= hold;
              hold_full <= 1'b0;
              bit_cnt   <= '0;
              state     <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end

          default: begin
            tx    <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_mode1.sv
// Self-checking bench for uart_tx_mode1 against a frame-level reference model.
module tb_uart_tx_mode1;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_baud;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic       ti;
  logic       ti_clr;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a frame is the 10 line values {stop, data, start};
  // m_pos is the index of the bit on the line, -1 when idle.
  logic [9:0] m_frame;
  int         m_pos;
  logic       m_hv;
  logic [7:0] m_hb;
  logic       m_ti;
  logic       m_done;
  logic       m_tx;

  uart_tx_mode1 #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_baud (tick_baud),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .ti        (ti),
    .ti_clr    (ti_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] model_vec();
    return {m_tx, m_done, m_ti, (m_pos >= 0) || m_hv, !m_hv};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {tx, tx_done, ti, tx_busy, wr_ready};
  endfunction

  task automatic model_reset();
    m_pos = -1; m_hv = 1'b0; m_hb = 8'h00; m_ti = 1'b0;
    m_done = 1'b0; m_tx = 1'b1; m_frame = 10'h3FF;
  endtask

  task automatic model_clock(input logic tk, input logic we, input logic [7:0] d,
                             input logic clr);
    logic acc;
    acc    = we && !m_hv;
    m_done = 1'b0;
    if (tk) begin
      if (m_pos < 0) begin
        if (m_hv) begin
          m_frame = {1'b1, m_hb, 1'b0}; m_pos = 0; m_hv = 1'b0;
        end
      end else if (m_pos < 9) begin
        m_pos++;
      end else begin
        m_done = 1'b1;
        if (m_hv) begin
          m_frame = {1'b1, m_hb, 1'b0}; m_pos = 0; m_hv = 1'b0;
        end else begin
          m_pos = -1;
        end
      end
    end
    if (acc) begin
      m_hv = 1'b1; m_hb = d;
    end
    if (m_done) m_ti = 1'b1;
    else if (clr) m_ti = 1'b0;
    m_tx = (m_pos < 0) ? 1'b1 : m_frame[m_pos];
  endtask

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, return 1 time unit later ready for sampling.
  task automatic step(input logic tk, input logic we, input logic [7:0] d,
                      input logic clr);
    @(negedge clk);
    tick_baud = tk; wr_en = we; wr_data = d; ti_clr = clr;
    @(posedge clk);
    model_clock(tk, we, d, clr);
    #1;
    tick_baud = 1'b0; wr_en = 1'b0; ti_clr = 1'b0;
  endtask

  task automatic gap();
    int n;
    n = int'($urandom_range(0, 2));
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick_baud = 1'b0; wr_en = 1'b0; ti_clr = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (dut_vec() !== 5'b10001) begin
      n_fail++;
      $display("FAIL reset_state: got {tx,done,ti,busy,ready}=%b want 10001", dut_vec());
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      n_chk++;
      if (dut_vec() !== 5'b10001) begin
        n_fail++;
        $display("FAIL idle_tick%0d: got %b want 10001", i, dut_vec());
      end
      gap();
    end
  endtask

  task automatic test_single();
    logic [9:0] seq;
    int dones;
    seq = '0; dones = 0;
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    n_chk++;
    if ({tx_busy, wr_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_write: got busy,ready=%b want 10", {tx_busy, wr_ready});
    end
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      if (i < 10) seq[i] = tx;
      if (tx_done === 1'b1) dones++;
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL single_tick%0d: got %b want %b", i, dut_vec(), model_vec());
      end
      gap();
    end
    n_chk++;
    if (seq !== 10'b1101001010 || dones != 1) begin
      n_fail++;
      $display("FAIL single_seq: got bits=%b dones=%0d want 1101001010 dones=1", seq, dones);
    end
    n_chk++;
    if ({ti, tx_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_end: got ti,busy=%b want 10", {ti, tx_busy});
    end
  endtask

  task automatic test_back_to_back();
    int d0, d1, dones;
    d0 = -1; d1 = -1; dones = 0;
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 22; i++) begin
      if (i == 4) begin
        n_chk++;
        if (wr_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready: got %b want 1", wr_ready);
        end
        step(1'b0, 1'b1, 8'hC3, 1'b0);
      end
      step(1'b1, 1'b0, 8'h00, 1'b0);
      if (tx_done === 1'b1) begin
        if (dones == 0) d0 = i; else d1 = i;
        dones++;
      end
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL b2b_tick%0d: got %b want %b", i, dut_vec(), model_vec());
      end
      gap();
    end
    n_chk++;
    if (dones != 2 || d0 != 10 || d1 != 20) begin
      n_fail++;
      $display("FAIL b2b_done: got count=%0d at %0d,%0d want 2 at 10,20", dones, d0, d1);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] seq2;
    int dones;
    seq2 = '0; dones = 0;
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    n_chk++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_ready: got %b want 0", wr_ready);
    end
    step(1'b0, 1'b1, 8'h33, 1'b0);
    for (int i = 1; i < 26; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      if (i >= 10 && i < 20) seq2[i-10] = tx;
      if (tx_done === 1'b1) dones++;
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL ovf_tick%0d: got %b want %b", i, dut_vec(), model_vec());
      end
    end
    n_chk++;
    if (seq2 !== 10'b1001000100 || dones != 2 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_frames: got bits2=%b dones=%0d busy=%b want 1001000100 2 0",
               seq2, dones, tx_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] seq;
    int dones;
    seq = '0; dones = 0;
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    do_reset();
    n_chk++;
    if (dut_vec() !== 5'b10001) begin
      n_fail++;
      $display("FAIL midrst_state: got %b want 10001", dut_vec());
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      n_chk++;
      if (dut_vec() !== 5'b10001) begin
        n_fail++;
        $display("FAIL midrst_quiet%0d: got %b want 10001", i, dut_vec());
      end
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      if (i < 10) seq[i] = tx;
      if (tx_done === 1'b1) dones++;
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL midrst_tick%0d: got %b want %b", i, dut_vec(), model_vec());
      end
    end
    n_chk++;
    if (seq !== 10'b1000000000 || dones != 1) begin
      n_fail++;
      $display("FAIL midrst_seq: got bits=%b dones=%0d want 1000000000 dones=1", seq, dones);
    end
  endtask

  task automatic test_ti();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_chk++;
    if (ti !== 1'b0) begin
      n_fail++;
      $display("FAIL ti_clear_first: got %b want 0", ti);
    end
    step(1'b0, 1'b1, 8'h96, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    n_chk++;
    if ({ti, tx_done} !== 2'b11) begin
      n_fail++;
      $display("FAIL ti_set_wins: got ti,done=%b want 11", {ti, tx_done});
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_chk++;
    if (ti !== 1'b0) begin
      n_fail++;
      $display("FAIL ti_later_clear: got %b want 0", ti);
    end
  endtask

  task automatic test_random();
    logic tk, we, clr;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      tk  = ($urandom_range(0, 2) == 0);
      we  = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 15) == 0);
      d   = 8'($urandom);
      step(tk, we, d, clr);
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL rand_cyc%0d: got %b want %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; tick_baud = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ti_clr = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_ti();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
